// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared opcode constants and state encoding for the multi-cycle control unit.
package multi_cycle_ctrl_pkg;

  localparam logic [3:0] kLOAD   = 4'b0110;
  localparam logic [3:0] kSTORE  = 4'b0111;
  localparam logic [3:0] kBRANCH = 4'b1010;
  localparam logic [3:0] kHALT   = 4'b1111;
  localparam logic [3:0] kRSH    = 4'b0101;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } ctrl_state_t;

endpackage

// File: rtl/multi_cycle_ctrl_mem_timeout_timer.sv
// 8-bit cycle counter bounding how long a data-memory request may wait for its ack.
module mem_timeout_timer
  import multi_cycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       expire
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  // count holds the number of completed wait cycles, so the limit-th cycle expires
  assign expire = en && (count == limit - 8'd1);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB with memory timeout and retire count.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int INSTR_W    = 9,
  parameter int OP_W       = 4,
  parameter int BR_ON_ZERO = 1,
  parameter int MEM_TMO    = 15,
  parameter int CNT_W      = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               Zero,
  input  logic               MemAck,
  output logic               InstrLoad,
  output logic               PcInc,
  output logic               BranchEn,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               Done,
  output logic               Fault,
  output logic [CNT_W-1:0]   InstrCount
);

  ctrl_state_t       state;
  logic              armed;
  logic              done_flag;
  logic              fault_flag;
  logic [OP_W-1:0]   opcode;
  logic [CNT_W-1:0]  count;
  logic              is_load, is_store, is_branch, is_halt;
  logic              taken, expire, retire;
  logic              unused_operand;

  assign unused_operand = ^Instruction[INSTR_W-OP_W-1:0];

  assign is_load   = (opcode == OP_W'(kLOAD));
  assign is_store  = (opcode == OP_W'(kSTORE));
  assign is_branch = (opcode == OP_W'(kBRANCH));
  assign is_halt   = (opcode == OP_W'(kHALT));
  assign taken     = is_branch && (Zero || (BR_ON_ZERO == 0));

  mem_timeout_timer u_timer (
    .clk    (Clk),
    .rst_n  (Reset),
    .load   (state == DECODE),
    .en     (state == MEM),
    .limit  (8'(MEM_TMO)),
    .expire (expire)
  );

  always_comb begin
    InstrLoad = 1'b0;
    PcInc     = 1'b0;
    BranchEn  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    case (state)
      FETCH: InstrLoad = 1'b1;
      EXEC: begin
        BranchEn = taken;
        PcInc    = is_branch && !taken;
      end
      MEM: begin
        MemWrite = is_store;
        MemRead  = !is_store;
        PcInc    = is_store && MemAck;
      end
      WB: begin
        RegWrite = 1'b1;
        PcInc    = 1'b1;
      end
      default: ;
    endcase
  end

  assign retire     = PcInc || BranchEn;
  assign Done       = done_flag && !fault_flag;
  assign Fault      = fault_flag;
  assign InstrCount = count;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      armed      <= 1'b0;
      done_flag  <= 1'b0;
      fault_flag <= 1'b0;
      opcode     <= '0;
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            armed <= 1'b1;
          end else if (armed) begin
            state      <= FETCH;
            armed      <= 1'b0;
            count      <= '0;
            done_flag  <= 1'b0;
            fault_flag <= 1'b0;
          end
        end
        HALT: begin
          if (Start) begin
            state <= IDLE;
            armed <= 1'b1;
          end
        end
        default: begin
          // Start while running aborts the instruction; the retire count is frozen below
          if (Start) begin
            state <= IDLE;
            armed <= 1'b1;
          end else begin
            case (state)
              FETCH: begin
                opcode <= Instruction[INSTR_W-1 -: OP_W];
                state  <= DECODE;
              end
              DECODE: begin
                if (is_halt) begin
                  state     <= HALT;
                  done_flag <= 1'b1;
                end else if (is_load || is_store) begin
                  state <= MEM;
                end else begin
                  state <= EXEC;
                end
              end
              EXEC: state <= is_branch ? FETCH : WB;
              MEM: begin
                if (MemAck) begin
                  state <= is_store ? FETCH : WB;
                end else if (expire) begin
                  state      <= HALT;
                  fault_flag <= 1'b1;
                end
              end
              WB:      state <= FETCH;
              default: state <= IDLE;
            endcase
          end
        end
      endcase

      if (retire && !Start && count != {CNT_W{1'b1}}) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized self-checking bench: per-instruction expected strobe sequences for two parameterisations.
module tb_multi_cycle_ctrl;

  localparam int TMO = 15;
  localparam logic [3:0] OP_LOAD  = 4'b0110;
  localparam logic [3:0] OP_STORE = 4'b0111;
  localparam logic [3:0] OP_BR    = 4'b1010;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  // strobe vector layout {InstrLoad, PcInc, BranchEn, MemRead, MemWrite, RegWrite}
  localparam logic [5:0] S_IL = 6'b100000;
  localparam logic [5:0] S_PC = 6'b010000;
  localparam logic [5:0] S_BE = 6'b001000;
  localparam logic [5:0] S_MR = 6'b000100;
  localparam logic [5:0] S_MW = 6'b000010;
  localparam logic [5:0] S_RW = 6'b000001;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [8:0] Instruction = '0;
  logic       Zero = 1'b0;
  logic       MemAck = 1'b0;

  logic a_il, a_pc, a_be, a_mr, a_mw, a_rw, a_done, a_fault;
  logic b_il, b_pc, b_be, b_mr, b_mw, b_rw, b_done, b_fault;
  logic [15:0] a_count;
  logic [1:0]  b_count;

  multi_cycle_ctrl dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction), .Zero(Zero),
    .MemAck(MemAck), .InstrLoad(a_il), .PcInc(a_pc), .BranchEn(a_be), .MemRead(a_mr),
    .MemWrite(a_mw), .RegWrite(a_rw), .Done(a_done), .Fault(a_fault), .InstrCount(a_count)
  );

  multi_cycle_ctrl #(.BR_ON_ZERO(0), .CNT_W(2)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction), .Zero(Zero),
    .MemAck(MemAck), .InstrLoad(b_il), .PcInc(b_pc), .BranchEn(b_be), .MemRead(b_mr),
    .MemWrite(b_mw), .RegWrite(b_rw), .Done(b_done), .Fault(b_fault), .InstrCount(b_count)
  );

  always #5 Clk = ~Clk;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  exp_count = 0;
  bit  exp_done = 1'b0;
  bit  exp_fault = 1'b0;
  bit  halted = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] vec_a();
    return {a_il, a_pc, a_be, a_mr, a_mw, a_rw};
  endfunction

  function automatic logic [5:0] vec_b();
    return {b_il, b_pc, b_be, b_mr, b_mw, b_rw};
  endfunction

  function automatic int sat_b(input int c);
    return (c > 3) ? 3 : c;
  endfunction

  task automatic check_count(input string tag);
    check({tag, ".cnt_a"}, 32'(a_count), 32'(exp_count));
    check({tag, ".cnt_b"}, 32'(b_count), 32'(sat_b(exp_count)));
  endtask

  // Called at posedge+1; compares at the following falling edge, returns at next posedge+1.
  task automatic cycle(input string tag, input logic [5:0] ea, input logic [5:0] eb);
    @(negedge Clk);
    check({tag, ".strobe_a"}, 32'(vec_a()), 32'(ea));
    check({tag, ".strobe_b"}, 32'(vec_b()), 32'(eb));
    check({tag, ".done"}, {30'd0, a_done, b_done}, {30'd0, exp_done, exp_done});
    check({tag, ".fault"}, {30'd0, a_fault, b_fault}, {30'd0, exp_fault, exp_fault});
    @(posedge Clk);
    #1;
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    cycle("start_hi", 6'd0, 6'd0);
    Start = 1'b0;
    cycle("start_lo", 6'd0, 6'd0);
    exp_done  = 1'b0;
    exp_fault = 1'b0;
    exp_count = 0;
    halted    = 1'b0;
  endtask

  // ack_at: MEM cycle (1..TMO) on which MemAck pulses, 0 = never
  task automatic run_instr(input logic [3:0] op, input logic [4:0] lo, input bit z, input int ack_at);
    logic [5:0] ea;
    Instruction = {op, lo};
    Zero        = z;
    MemAck      = 1'b0;
    check_count("fetch");
    cycle("fetch", S_IL, S_IL);
    Instruction = 9'($urandom);
    cycle("decode", 6'd0, 6'd0);
    if (op == OP_HALT) begin
      exp_done = 1'b1;
      halted   = 1'b1;
      cycle("halt", 6'd0, 6'd0);
      check_count("halt");
    end else if (op == OP_LOAD || op == OP_STORE) begin
      for (int k = 1; k <= TMO; k++) begin
        MemAck = (k == ack_at);
        ea = (op == OP_STORE) ? S_MW : S_MR;
        if (MemAck && op == OP_STORE) ea |= S_PC;
        cycle("mem", ea, ea);
        if (k == ack_at) break;
      end
      MemAck = 1'b0;
      if (ack_at == 0) begin
        exp_fault = 1'b1;
        halted    = 1'b1;
        cycle("timeout", 6'd0, 6'd0);
        check_count("timeout");
      end else begin
        if (op == OP_LOAD) cycle("load_wb", S_RW | S_PC, S_RW | S_PC);
        exp_count++;
      end
    end else if (op == OP_BR) begin
      cycle("branch", z ? S_BE : S_PC, S_BE);
      exp_count++;
    end else begin
      cycle("exec", 6'd0, 6'd0);
      cycle("wb", S_RW | S_PC, S_RW | S_PC);
      exp_count++;
    end
    $display("instr op=%h lo=%h zero=%0d ack_at=%0d -> count=%0d done=%0d fault=%0d",
             op, lo, z, ack_at, exp_count, exp_done, exp_fault);
  endtask

  initial begin
    logic [3:0] op;
    // reset state
    repeat (3) @(posedge Clk);
    #1;
    check("reset.strobe_a", 32'(vec_a()), 32'd0);
    check("reset.strobe_b", 32'(vec_b()), 32'd0);
    check_count("reset");
    Reset = 1'b1;
    cycle("idle", 6'd0, 6'd0);

    // ALU ops then halt
    start_pulse();
    run_instr(4'b0001, 5'd0, 1'b0, 0);
    run_instr(4'b0010, 5'd7, 1'b1, 0);
    run_instr(4'b0011, 5'd9, 1'b0, 0);
    run_instr(OP_HALT, 5'd0, 1'b0, 0);

    // branches, memory handshakes, ack on the timeout cycle, then timeout fault
    start_pulse();
    run_instr(OP_BR, 5'd1, 1'b1, 0);
    run_instr(OP_BR, 5'd2, 1'b0, 0);
    run_instr(OP_STORE, 5'd3, 1'b0, 3);
    run_instr(OP_LOAD, 5'd4, 1'b0, 3);
    run_instr(OP_LOAD, 5'd5, 1'b0, TMO);
    run_instr(OP_STORE, 5'd6, 1'b0, 1);
    run_instr(4'b0101, 5'd7, 1'b0, 0);
    run_instr(OP_LOAD, 5'd8, 1'b0, 0);

    // abort during EXEC: no WB, count holds until restart
    start_pulse();
    run_instr(4'b0001, 5'd0, 1'b0, 0);
    Instruction = {4'b0010, 5'd3};
    cycle("ab_fetch", S_IL, S_IL);
    cycle("ab_decode", 6'd0, 6'd0);
    Start = 1'b1;
    cycle("ab_exec", 6'd0, 6'd0);
    Start = 1'b0;
    check_count("ab_idle");
    cycle("ab_idle", 6'd0, 6'd0);
    exp_count = 0;
    run_instr(4'b0100, 5'd1, 1'b0, 0);

    // asynchronous reset while a store is pending
    run_instr(4'b0001, 5'd2, 1'b0, 0);
    Instruction = {OP_STORE, 5'd0};
    cycle("rs_fetch", S_IL, S_IL);
    cycle("rs_decode", 6'd0, 6'd0);
    cycle("rs_mem1", S_MW, S_MW);
    cycle("rs_mem2", S_MW, S_MW);
    check("rs_pre.mw", 32'(a_mw), 32'd1);
    #1 Reset = 1'b0;
    #1;
    check("rs_async.strobe_a", 32'(vec_a()), 32'd0);
    check("rs_async.strobe_b", 32'(vec_b()), 32'd0);
    exp_count = 0;
    check_count("rs_async");
    @(negedge Clk);
    #2 Reset = 1'b1;
    @(posedge Clk);
    #1;
    cycle("rs_idle1", 6'd0, 6'd0);
    cycle("rs_idle2", 6'd0, 6'd0);
    halted = 1'b1;

    // random instruction stream
    for (int i = 0; i < 300; i++) begin
      if (halted) start_pulse();
      op = 4'($urandom);
      run_instr(op, 5'($urandom), 1'($urandom), int'($urandom_range(0, TMO)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
